multicycle_multiply_unit: RTL and testbench

- Iterative multiply / multiply-accumulate unit for the processor datapath.
- Replaces the single-cycle combinational multiply path in the ALU for the mul, mla, umull, umlal, smull and smlal instructions.
- Trades latency for area through a configurable number of multiplier bits retired per cycle.
- The control unit issues an operation with start, then waits for done before writeback to rd/rn and cpsr.

---
 rtl/multicycle_multiply_unit.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_multicycle_multiply_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_multiply_unit.sv
// -----------------------------------------------------------------------------
// multicycle_multiply_unit
//
// Iterative multiply / multiply-accumulate unit. An operation is accepted with
// a start strobe while idle. The unit then retires BITS_PER_CYCLE multiplier
// bits per cycle, LSB first, into a 2*WIDTH partial product. One final cycle
// applies the sign, adds the accumulate term and updates the flags.
//
// Opcodes: 0000 mul, 0001 mla, 0100 umull, 0101 umlal, 0110 smull, 0111 smlal.
// Any other opcode completes on the accepting edge with illegal set. In that
// case result and flags are left untouched.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   opcode     operation select
//   set_flags  update n_flag/z_flag on completion, sampled with start
//   a          multiplicand (rm)
//   b          multiplier (rs)
//   c          mla addend / high accumulate word for long forms
//   d          low accumulate word for long forms
//   busy       operation in progress
//   done       one-cycle completion pulse
//   result     2*WIDTH result, held until the next completion
//   n_flag     negative flag
//   z_flag     zero flag
//   illegal    last completion was an undefined opcode
// -----------------------------------------------------------------------------
module multicycle_multiply_unit #(
   parameter int unsigned WIDTH          = 32,
   // Must be a power of two that divides WIDTH.
   parameter int unsigned BITS_PER_CYCLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [3:0]           opcode,
   input  logic                 set_flags,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [WIDTH-1:0]     c,
   input  logic [WIDTH-1:0]     d,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 n_flag,
   output logic                 z_flag,
   output logic                 illegal
);

   localparam int unsigned ProdW   = 2 * WIDTH;
   localparam int unsigned NumIter = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CntW    = $clog2(NumIter + 1);

   typedef enum logic [1:0] {
      StIdle,
      StIter,
      StFix
   } state_e;

   state_e state_q, state_d;

   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             long_q, long_d;       // 64-bit significant width
   logic             acc_q, acc_d;         // accumulate form
   logic             neg_q, neg_d;         // final product must be negated
   logic             flags_en_q, flags_en_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [ProdW-1:0] mcand_q, mcand_d;     // multiplicand, shifted left each step
   logic [WIDTH-1:0] mplier_q, mplier_d;   // multiplier, shifted right each step
   logic [ProdW-1:0] prod_q, prod_d;
   logic [ProdW-1:0] result_q, result_d;
   logic             n_q, n_d;
   logic             z_q, z_d;
   logic             done_q, done_d;
   logic             illegal_q, illegal_d;

   // ---------------------------------------------------------------------------
   // Opcode decode of the incoming request
   // ---------------------------------------------------------------------------
   logic dec_legal, dec_long, dec_acc, dec_signed;

   always_comb begin
      dec_legal  = 1'b1;
      dec_long   = 1'b0;
      dec_acc    = 1'b0;
      dec_signed = 1'b0;
      case (opcode)
         4'b0000: dec_legal = 1'b1;
         4'b0001: dec_acc   = 1'b1;
         4'b0100: dec_long  = 1'b1;
         4'b0101: begin
            dec_long = 1'b1;
            dec_acc  = 1'b1;
         end
         4'b0110: begin
            dec_long   = 1'b1;
            dec_signed = 1'b1;
         end
         4'b0111: begin
            dec_long   = 1'b1;
            dec_signed = 1'b1;
            dec_acc    = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Operand magnitudes. The most negative value maps to 2^(WIDTH-1) when it is
   // read as an unsigned WIDTH-bit number, so no extra bit is needed.
   logic [WIDTH-1:0] mag_a, mag_b;

   always_comb begin
      mag_a = (dec_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
      mag_b = (dec_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
   end

   // ---------------------------------------------------------------------------
   // One shift-add step: partial sum of the low BITS_PER_CYCLE multiplier bits
   // ---------------------------------------------------------------------------
   logic [ProdW-1:0] step_sum;

   always_comb begin
      step_sum = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (mplier_q[i]) begin
            step_sum = step_sum + (mcand_q << i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Final fix-up: sign, accumulate and flags
   // ---------------------------------------------------------------------------
   logic [ProdW-1:0] prod_signed;
   logic [WIDTH-1:0] short_val;
   logic [ProdW-1:0] fix_val;
   logic             fix_n, fix_z;

   always_comb begin
      prod_signed = neg_q ? ({ProdW{1'b0}} - prod_q) : prod_q;
      short_val   = prod_q[WIDTH-1:0] + (acc_q ? acc_hi_q : {WIDTH{1'b0}});
      if (long_q) begin
         fix_val = prod_signed + (acc_q ? {acc_hi_q, acc_lo_q} : {ProdW{1'b0}});
         fix_n   = fix_val[ProdW-1];
         fix_z   = (fix_val == {ProdW{1'b0}});
      end else begin
         // Short forms only keep the low word; the upper half reads as zero.
         fix_val = {{WIDTH{1'b0}}, short_val};
         fix_n   = short_val[WIDTH-1];
         fix_z   = (short_val == {WIDTH{1'b0}});
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start && dec_legal) begin
               state_d = StIter;
            end
         end
         StIter: begin
            if (cnt_q == CntW'(NumIter - 1)) begin
               state_d = StFix;
            end
         end
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q != StIdle);
   end

   // ---------------------------------------------------------------------------
   // Datapath next state
   // ---------------------------------------------------------------------------
   always_comb begin
      cnt_d      = cnt_q;
      long_d     = long_q;
      acc_d      = acc_q;
      neg_d      = neg_q;
      flags_en_d = flags_en_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      prod_d     = prod_q;
      result_d   = result_q;
      n_d        = n_q;
      z_d        = z_q;
      done_d     = 1'b0;
      illegal_d  = illegal_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (dec_legal) begin
                  long_d     = dec_long;
                  acc_d      = dec_acc;
                  flags_en_d = set_flags;
                  acc_hi_d   = c;
                  acc_lo_d   = d;
                  neg_d      = dec_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  mcand_d    = {{WIDTH{1'b0}}, mag_a};
                  mplier_d   = mag_b;
                  prod_d     = '0;
                  cnt_d      = '0;
               end else begin
                  // Undefined opcode: complete at once, result and flags kept.
                  done_d    = 1'b1;
                  illegal_d = 1'b1;
               end
            end
         end
         StIter: begin
            prod_d   = prod_q + step_sum;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + CntW'(1);
         end
         StFix: begin
            result_d  = fix_val;
            done_d    = 1'b1;
            illegal_d = 1'b0;
            cnt_d     = '0;
            if (flags_en_q) begin
               n_d = fix_n;
               z_d = fix_z;
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         long_q     <= 1'b0;
         acc_q      <= 1'b0;
         neg_q      <= 1'b0;
         flags_en_q <= 1'b0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         prod_q     <= '0;
         result_q   <= '0;
         n_q        <= 1'b0;
         z_q        <= 1'b0;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         long_q     <= long_d;
         acc_q      <= acc_d;
         neg_q      <= neg_d;
         flags_en_q <= flags_en_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         prod_q     <= prod_d;
         result_q   <= result_d;
         n_q        <= n_d;
         z_q        <= z_d;
         done_q     <= done_d;
         illegal_q  <= illegal_d;
      end
   end

   assign done    = done_q;
   assign result  = result_q;
   assign n_flag  = n_q;
   assign z_flag  = z_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_multiply_unit.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_multiply_unit. A directed vector table, hand-written
// corner sequences and randomized operations checked against an arithmetic
// reference model. Extra instances cover other BITS_PER_CYCLE and WIDTH values.
// -----------------------------------------------------------------------------
module tb_multicycle_multiply_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  opcode;
   logic        set_flags;
   logic [31:0] a, b, c, d;

   logic        busy, done, n_flag, z_flag, illegal;
   logic [63:0] result;

   logic        busy_b1, done_b1, n_b1, z_b1, ill_b1;
   logic [63:0] res_b1;
   logic        busy_b4, done_b4, n_b4, z_b4, ill_b4;
   logic [63:0] res_b4;
   logic        busy_w16, done_w16, n_w16, z_w16, ill_w16;
   logic [31:0] res_w16;

   always #5 clk = ~clk;

   multicycle_multiply_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .set_flags(set_flags),
      .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .result(result),
      .n_flag(n_flag), .z_flag(z_flag), .illegal(illegal)
   );

   multicycle_multiply_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_b1 (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .set_flags(set_flags),
      .a(a), .b(b), .c(c), .d(d), .busy(busy_b1), .done(done_b1), .result(res_b1),
      .n_flag(n_b1), .z_flag(z_b1), .illegal(ill_b1)
   );

   multicycle_multiply_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut_b4 (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .set_flags(set_flags),
      .a(a), .b(b), .c(c), .d(d), .busy(busy_b4), .done(done_b4), .result(res_b4),
      .n_flag(n_b4), .z_flag(z_b4), .illegal(ill_b4)
   );

   multicycle_multiply_unit #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut_w16 (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .set_flags(set_flags),
      .a(a[15:0]), .b(b[15:0]), .c(c[15:0]), .d(d[15:0]), .busy(busy_w16),
      .done(done_w16), .result(res_w16), .n_flag(n_w16), .z_flag(z_w16), .illegal(ill_w16)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: architectural result of each operation, plain arithmetic
   // ---------------------------------------------------------------------------
   logic [63:0] m_res;
   logic        m_n, m_z, m_ill;
   int          m_lat;

   task automatic model_apply(input logic [3:0] op, input logic sf,
                              input logic [31:0] ma, input logic [31:0] mb,
                              input logic [31:0] mc, input logic [31:0] md);
      logic [63:0] full;
      logic [31:0] lo;
      logic        legal;
      logic        is_long;
      legal   = 1'b1;
      is_long = 1'b1;
      full    = '0;
      case (op)
         4'b0000: begin lo = ma * mb;      full = {32'h0, lo}; is_long = 1'b0; end
         4'b0001: begin lo = ma * mb + mc; full = {32'h0, lo}; is_long = 1'b0; end
         4'b0100: full = {32'h0, ma} * {32'h0, mb};
         4'b0101: full = {32'h0, ma} * {32'h0, mb} + {mc, md};
         4'b0110: full = {{32{ma[31]}}, ma} * {{32{mb[31]}}, mb};
         4'b0111: full = {{32{ma[31]}}, ma} * {{32{mb[31]}}, mb} + {mc, md};
         default: legal = 1'b0;
      endcase
      if (legal) begin
         m_res = full;
         m_ill = 1'b0;
         m_lat = 17;
         if (sf) begin
            m_n = is_long ? full[63] : full[31];
            m_z = is_long ? (full == 64'h0) : (full[31:0] == 32'h0);
         end
      end else begin
         m_ill = 1'b1;
         m_lat = 0;
      end
   endtask

   // Drive a request at a negedge; the following posedge samples it. Inputs are
   // scrambled afterwards since the unit must have latched them.
   task automatic issue(input logic [3:0] op, input logic sf, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] ic, input logic [31:0] id);
      opcode    = op;
      set_flags = sf;
      a = ia; b = ib; c = ic; d = id;
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      opcode    = 4'($urandom);
      set_flags = 1'($urandom);
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
   endtask

   // lat counts rising edges since the accepting edge.
   task automatic wait_done(input int exp_lat, input int lat0, input string tag);
      int   lat;
      logic busy_ok;
      lat     = lat0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 60) begin
         if (busy !== (lat < exp_lat)) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (busy !== 1'b0) busy_ok = 1'b0;
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy"}, {63'h0, busy_ok}, 64'h1);
   endtask

   task automatic check_outs(input string tag, input logic [63:0] er, input logic en,
                             input logic ez, input logic ei);
      check({tag, "_result"}, result, er);
      check({tag, "_n"}, {63'h0, n_flag}, {63'h0, en});
      check({tag, "_z"}, {63'h0, z_flag}, {63'h0, ez});
      check({tag, "_illegal"}, {63'h0, illegal}, {63'h0, ei});
   endtask

   typedef struct {
      logic [3:0]  op;
      logic        sf;
      logic [31:0] a, b, c, d;
      logic [63:0] res;
      logic        n, z, ill;
      int          lat;
   } vec_t;

   vec_t vt[13];

   logic [3:0] op_pool[8];

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int l_main, l_b1, l_b4, l_w16;
      logic saw_done;

      vt[0]  = '{4'b0100, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                 64'hFFFFFFFE_00000001, 1'b0, 1'b0, 1'b0, 17};
      vt[1]  = '{4'b0110, 1'b0, 32'h80000000, 32'h80000000, 32'h0, 32'h0,
                 64'h40000000_00000000, 1'b0, 1'b0, 1'b0, 17};
      vt[2]  = '{4'b0110, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0,
                 64'hFFFFFFFF_FFFFFFFE, 1'b1, 1'b0, 1'b0, 17};
      vt[3]  = '{4'b0001, 1'b1, 32'h3, 32'h5, 32'hFFFFFFF1, 32'h0,
                 64'h0, 1'b0, 1'b1, 1'b0, 17};
      vt[4]  = '{4'b0001, 1'b0, 32'h3, 32'h5, 32'hFFFFFFF1, 32'h0,
                 64'h0, 1'b0, 1'b1, 1'b0, 17};
      vt[5]  = '{4'b0000, 1'b0, 32'h1, 32'h80000000, 32'h0, 32'h0,
                 64'h00000000_80000000, 1'b0, 1'b1, 1'b0, 17};
      vt[6]  = '{4'b0111, 1'b1, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h5,
                 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1'b0, 17};
      vt[7]  = '{4'b0101, 1'b1, 32'h2, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 64'h5, 1'b0, 1'b0, 1'b0, 17};
      vt[8]  = '{4'b0010, 1'b1, 32'h7, 32'h7, 32'h0, 32'h0,
                 64'h5, 1'b0, 1'b0, 1'b1, 0};
      vt[9]  = '{4'b0001, 1'b1, 32'h7, 32'h6, 32'h1, 32'h0,
                 64'h2B, 1'b0, 1'b0, 1'b0, 17};
      vt[10] = '{4'b0000, 1'b1, 32'h00010000, 32'h00010000, 32'h0, 32'h0,
                 64'h0, 1'b0, 1'b1, 1'b0, 17};
      vt[11] = '{4'b0000, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                 64'h1, 1'b0, 1'b1, 1'b0, 17};
      vt[12] = '{4'b0001, 1'b1, 32'h40000000, 32'h2, 32'h0, 32'h0,
                 64'h80000000, 1'b1, 1'b0, 1'b0, 17};

      op_pool = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b0010, 4'b1111};

      m_res = '0; m_n = 1'b0; m_z = 1'b0; m_ill = 1'b0; m_lat = 17;

      rst_n = 1'b0;
      start = 1'b0;
      opcode = '0; set_flags = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {63'h0, busy}, 64'h0);
      check("reset_done", {63'h0, done}, 64'h0);
      check_outs("reset", 64'h0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table; every op is issued in the done cycle of the previous one.
      for (int i = 0; i < 13; i++) begin
         issue(vt[i].op, vt[i].sf, vt[i].a, vt[i].b, vt[i].c, vt[i].d);
         model_apply(vt[i].op, vt[i].sf, vt[i].a, vt[i].b, vt[i].c, vt[i].d);
         wait_done(vt[i].lat, 0, $sformatf("vec%0d", i));
         check_outs($sformatf("vec%0d", i), vt[i].res, vt[i].n, vt[i].z, vt[i].ill);
      end

      // Start pulsed mid-operation with different inputs is ignored.
      issue(4'b0100, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0);
      model_apply(4'b0100, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0);
      repeat (5) @(negedge clk);
      opcode = 4'b0000; set_flags = 1'b1; a = 32'h3; b = 32'h3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(17, 6, "midstart");
      check_outs("midstart", m_res, m_n, m_z, m_ill);

      // Load non-zero state, then reset in the middle of an operation.
      issue(4'b0110, 1'b1, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0);
      model_apply(4'b0110, 1'b1, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0);
      wait_done(m_lat, 0, "pre_reset");
      issue(4'b1111, 1'b1, 32'h1, 32'h1, 32'h0, 32'h0);
      model_apply(4'b1111, 1'b1, 32'h1, 32'h1, 32'h0, 32'h0);
      wait_done(m_lat, 0, "pre_reset_ill");
      check_outs("pre_reset_ill", m_res, m_n, m_z, m_ill);
      issue(4'b0100, 1'b1, 32'h1234, 32'h5678, 32'h0, 32'h0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_busy", {63'h0, busy}, 64'h0);
      check("midreset_done", {63'h0, done}, 64'h0);
      check_outs("midreset", 64'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("no_done_after_reset", {63'h0, saw_done}, 64'h0);
      m_res = '0; m_n = 1'b0; m_z = 1'b0; m_ill = 1'b0;
      issue(4'b0101, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h11111111, 32'h22222222);
      model_apply(4'b0101, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h11111111, 32'h22222222);
      wait_done(m_lat, 0, "post_reset");
      check_outs("post_reset", m_res, m_n, m_z, m_ill);

      // Randomized back-to-back operations against the model.
      for (int i = 0; i < 40; i++) begin
         logic [3:0]  rop;
         logic        rsf;
         logic [31:0] ra, rb, rc, rd;
         rop = op_pool[$urandom_range(0, 7)];
         rsf = 1'($urandom);
         ra = pick32(); rb = pick32(); rc = pick32(); rd = pick32();
         issue(rop, rsf, ra, rb, rc, rd);
         model_apply(rop, rsf, ra, rb, rc, rd);
         wait_done(m_lat, 0, $sformatf("rand%0d", i));
         check_outs($sformatf("rand%0d", i), m_res, m_n, m_z, m_ill);
      end

      // Latency of the other configurations, all started on the same edge.
      repeat (40) @(negedge clk);
      issue(4'b0100, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
      l_main = -1; l_b1 = -1; l_b4 = -1; l_w16 = -1;
      for (int k = 0; k < 45; k++) begin
         if (done === 1'b1 && l_main < 0) l_main = k;
         if (done_b1 === 1'b1 && l_b1 < 0) l_b1 = k;
         if (done_b4 === 1'b1 && l_b4 < 0) l_b4 = k;
         if (done_w16 === 1'b1 && l_w16 < 0) l_w16 = k;
         @(negedge clk);
      end
      check("lat_bpc2", 64'(l_main), 64'd17);
      check("lat_bpc1", 64'(l_b1), 64'd33);
      check("lat_bpc4", 64'(l_b4), 64'd9);
      check("lat_w16", 64'(l_w16), 64'd9);
      check("res_bpc2", result, 64'hFFFFFFFE_00000001);
      check("res_bpc1", res_b1, 64'hFFFFFFFE_00000001);
      check("res_bpc4", res_b4, 64'hFFFFFFFE_00000001);
      check("res_w16", {32'h0, res_w16}, 64'h00000000_FFFE0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
